// File: rtl/idu_inst_queue.sv
// Decode-side instruction queue: compacts fetch bundles into a circular buffer and presents the
// oldest entries to rename, gated by free-register credits. Optional perf counters: IDU_IQ_PERF_CNT_EN.
module idu_inst_queue #(
  parameter int FETCH_WIDTH     = 2,
  parameter int ISSUE_WIDTH     = 2,
  parameter int IQ_DEPTH        = 8,
  parameter int INST_ADDR_WIDTH = 32,
  parameter int CREDIT_WIDTH    = 6
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           flush,
  input  logic                                           in_valid,
  input  logic [FETCH_WIDTH-1:0]                         in_lane_valid,
  input  logic [FETCH_WIDTH-1:0][31:0]                   in_inst,
  input  logic [INST_ADDR_WIDTH-1:0]                     in_pc,
  output logic                                           in_ready,
  input  logic [CREDIT_WIDTH-1:0]                        rename_credits,
  input  logic                                           out_ready,
  output logic [ISSUE_WIDTH-1:0]                         out_valid,
  output logic [ISSUE_WIDTH-1:0][31:0]                   out_inst,
  output logic [ISSUE_WIDTH-1:0][INST_ADDR_WIDTH-1:0]    out_pc,
  output logic [ISSUE_WIDTH-1:0]                         out_needs_rd,
  output logic [$clog2(IQ_DEPTH):0]                      count
`ifdef IDU_IQ_PERF_CNT_EN
  ,
  output logic [31:0]                                    perf_stall_cycles,
  output logic [31:0]                                    perf_credit_starve
`endif
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]              head;
  logic [PW-1:0]              tail;
  logic [31:0]                mem_inst [IQ_DEPTH];
  logic [INST_ADDR_WIDTH-1:0] mem_pc   [IQ_DEPTH];
  logic                       mem_nrd  [IQ_DEPTH];

  logic                       push_fire;
  logic [CW-1:0]              push_cnt;
  logic [CW-1:0]              pop_cnt;
  logic [PW-1:0]              wr_idx   [FETCH_WIDTH];
  logic [PW-1:0]              rd_idx   [ISSUE_WIDTH];
  logic [31:0]                need_sum;
  logic                       prev_vld;

  assign in_ready  = (CW'(IQ_DEPTH) - count) >= CW'(FETCH_WIDTH);
  assign push_fire = in_valid & in_ready & ~flush;

  // Valid lanes land at tail + (number of valid lanes below them), skipping holes.
  always_comb begin
    push_cnt = '0;
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      wr_idx[j] = tail + push_cnt[PW-1:0];
      if (in_lane_valid[j]) push_cnt = push_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (in_lane_valid[j]) begin
          mem_inst[wr_idx[j]] <= in_inst[j];
          mem_pc[wr_idx[j]]   <= in_pc + INST_ADDR_WIDTH'(4 * j);
          mem_nrd[wr_idx[j]]  <= (in_inst[j][6:0] != 7'b0100011) &&
                                 (in_inst[j][6:0] != 7'b1100011) &&
                                 (in_inst[j][11:7] != 5'd0);
        end
      end
    end
  end

  // A lane is offered only if every older lane is offered and the running credit demand fits.
  always_comb begin
    need_sum = '0;
    prev_vld = 1'b1;
    pop_cnt  = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      rd_idx[i]       = head + PW'(i);
      out_inst[i]     = mem_inst[rd_idx[i]];
      out_pc[i]       = mem_pc[rd_idx[i]];
      out_needs_rd[i] = mem_nrd[rd_idx[i]];
      need_sum        = need_sum + {31'd0, out_needs_rd[i]};
      out_valid[i]    = prev_vld && (CW'(i) < count) &&
                        (need_sum <= 32'(rename_credits)) && !flush;
      prev_vld        = out_valid[i];
      if (out_valid[i] && out_ready) pop_cnt = pop_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + pop_cnt[PW-1:0];
      if (push_fire) tail <= tail + push_cnt[PW-1:0];
      count <= count + (push_fire ? push_cnt : CW'(0)) - pop_cnt;
    end
  end

`ifdef IDU_IQ_PERF_CNT_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles  <= '0;
      perf_credit_starve <= '0;
    end else begin
      if ((count != '0) && !out_ready && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if ((count != '0) && !out_valid[0] && !flush && (perf_credit_starve != '1))
        perf_credit_starve <= perf_credit_starve + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_idu_inst_queue.sv
// Bench for idu_inst_queue: directed scenarios then random traffic against a queue-based model.
module tb_idu_inst_queue;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic [1:0]       in_lane_valid;
  logic [1:0][31:0] in_inst;
  logic [31:0]      in_pc;
  logic             in_ready;
  logic [5:0]       rename_credits;
  logic             out_ready;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_inst;
  logic [1:0][31:0] out_pc;
  logic [1:0]       out_needs_rd;
  logic [3:0]       count;
`ifdef IDU_IQ_PERF_CNT_EN
  logic [31:0]      perf_stall_cycles;
  logic [31:0]      perf_credit_starve;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        nrd;
  } ent_t;
  ent_t q[$];
  int   m_stall  = 0;
  int   m_starve = 0;

  localparam logic [31:0] ADDI_X1 = 32'h00100093;
  localparam logic [31:0] ADDI_X2 = 32'h00100113;
  localparam logic [31:0] ADDI_X3 = 32'h00100193;
  localparam logic [31:0] SW_OP   = 32'h00112023;

  idu_inst_queue dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_lane_valid  (in_lane_valid),
    .in_inst        (in_inst),
    .in_pc          (in_pc),
    .in_ready       (in_ready),
    .rename_credits (rename_credits),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_needs_rd   (out_needs_rd),
    .count          (count)
`ifdef IDU_IQ_PERF_CNT_EN
    ,
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_credit_starve (perf_credit_starve)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic nrd_of(input logic [31:0] inst);
    return (inst[6:0] != 7'h23) && (inst[6:0] != 7'h63) && (inst[11:7] != 5'd0);
  endfunction

  // Oldest entries are offered while their cumulative register demand fits the credits.
  function automatic logic [1:0] exp_valid();
    logic [1:0] v = 2'b00;
    int sum = 0;
    if (!flush) begin
      for (int i = 0; i < 2; i++) begin
        if (i >= q.size()) break;
        sum += int'(q[i].nrd);
        if (sum > int'(rename_credits)) break;
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic check_outputs();
    logic [1:0] ev = exp_valid();
    check("count", 64'(count), 64'(q.size()));
    check("in_ready", 64'(in_ready), 64'(q.size() <= 6));
    check("out_valid", 64'(out_valid), 64'(ev));
    for (int i = 0; i < 2; i++) begin
      if (ev[i]) begin
        check("out_inst", 64'(out_inst[i]), 64'(q[i].inst));
        check("out_pc", 64'(out_pc[i]), 64'(q[i].pc));
        check("out_needs_rd", 64'(out_needs_rd[i]), 64'(q[i].nrd));
      end
    end
`ifdef IDU_IQ_PERF_CNT_EN
    check("perf_stall", 64'(perf_stall_cycles), 64'(m_stall));
    check("perf_starve", 64'(perf_credit_starve), 64'(m_starve));
`endif
  endtask

  // Applies the rules for one clock edge using the inputs held across it.
  task automatic model_update();
    logic [1:0] ev = exp_valid();
    logic       rdy = (q.size() <= 6);
    if (q.size() > 0 && !out_ready) m_stall++;
    if (q.size() > 0 && !ev[0] && !flush) m_starve++;
    if (flush) begin
      q.delete();
    end else begin
      if (out_ready)
        for (int i = 0; i < 2; i++) if (ev[i]) void'(q.pop_front());
      if (in_valid && rdy)
        for (int j = 0; j < 2; j++)
          if (in_lane_valid[j])
            q.push_back('{inst: in_inst[j], pc: in_pc + 32'(4 * j), nrd: nrd_of(in_inst[j])});
    end
  endtask

  task automatic cycle();
    #1 check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w = $urandom;
    logic [6:0]  ops [4] = '{7'h13, 7'h23, 7'h63, 7'h33};
    w[6:0]  = ops[$urandom_range(0, 3)];
    w[11:7] = 5'($urandom_range(0, 2));
    return w;
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_lane_valid = 2'b00;
    in_inst = '0; in_pc = '0; rename_credits = 6'd8; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_count", 64'(count), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full bundle pushes and pops the next cycle.
    in_valid = 1'b1; in_lane_valid = 2'b11; in_inst[0] = ADDI_X1; in_inst[1] = ADDI_X2; in_pc = 32'h100;
    cycle();
    in_valid = 1'b0;
    check("b1_valid", 64'(out_valid), 64'b11);
    check("b1_pc0", 64'(out_pc[0]), 64'h100);
    check("b1_pc1", 64'(out_pc[1]), 64'h104);
    check("b1_nrd", 64'(out_needs_rd), 64'b11);
    cycle();
    check("b1_drained", 64'(count), 64'd0);

    // Compaction of a lane-1-only bundle.
    out_ready = 1'b0; in_valid = 1'b1; in_lane_valid = 2'b10; in_inst[1] = ADDI_X1; in_pc = 32'h200;
    cycle();
    in_valid = 1'b0;
    check("compact_valid", 64'(out_valid), 64'b01);
    check("compact_pc", 64'(out_pc[0]), 64'h204);
    flush = 1'b1; cycle(); flush = 1'b0;

    // Fill to 7 (in_ready drops), refused push, drain; then fill to 8 across the wrap.
    in_valid = 1'b1; in_lane_valid = 2'b01; in_inst[0] = rand_inst(); cycle();
    in_lane_valid = 2'b11;
    repeat (3) begin in_inst[0] = rand_inst(); in_inst[1] = rand_inst(); cycle(); end
    check("fill7_count", 64'(count), 64'd7);
    check("fill7_in_ready", 64'(in_ready), 64'd0);
    cycle();
    check("refused_count", 64'(count), 64'd7);
    in_valid = 1'b0; out_ready = 1'b1; rename_credits = 6'd8;
    repeat (4) cycle();
    check("drain_count", 64'(count), 64'd0);
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (4) begin in_inst[0] = rand_inst(); in_inst[1] = rand_inst(); cycle(); end
    check("full_count", 64'(count), 64'd8);
    check("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();

    // Credit gating with a store at the head.
    out_ready = 1'b0; rename_credits = 6'd0; in_valid = 1'b1; in_lane_valid = 2'b11;
    in_inst[0] = SW_OP; in_inst[1] = ADDI_X3; in_pc = 32'h300;
    cycle();
    in_valid = 1'b0;
    check("credit0_valid", 64'(out_valid), 64'b01);
    rename_credits = 6'd1;
    #1 check("credit1_valid", 64'(out_valid), 64'b11);
    out_ready = 1'b1; cycle();

    // Push coincident with flush at count 5.
    out_ready = 1'b0; rename_credits = 6'd8; in_valid = 1'b1; in_lane_valid = 2'b01; cycle();
    in_lane_valid = 2'b11; repeat (2) cycle();
    check("pre_flush_count", 64'(count), 64'd5);
    flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    cycle();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      flush          = ($urandom_range(0, 15) == 0);
      in_valid       = ($urandom_range(0, 3) != 0);
      in_lane_valid  = 2'($urandom_range(0, 3));
      in_inst[0]     = rand_inst();
      in_inst[1]     = rand_inst();
      in_pc          = {$urandom, 2'b00} & 32'hffff_fffc;
      rename_credits = 6'($urandom_range(0, 3));
      out_ready      = ($urandom_range(0, 2) != 0);
      cycle();
    end
    flush = 1'b0;

    // Asynchronous reset in the middle of a cycle.
    out_ready = 1'b0; in_valid = 1'b1; in_lane_valid = 2'b11; cycle(); in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    q.delete(); m_stall = 0; m_starve = 0;
    @(negedge clk);
    reset = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
